mem_wb_sender: RTL and testbench

- MEM pipeline stage of the 5-stage CPU, and the transmitting end of the MEM→WB valid/allowin interface.
- Accepts EXE results over the same valid/allowin protocol and waits for the data-SRAM response on loads.
- Extracts and extends load data, then presents the 70-bit {rf_we, rf_waddr, rf_wdata, pc} bus to WB.
- Also publishes a forwarding/stall bundle to ID.

---
 rtl/mem_wb_sender.sv | 73 +++++++
 tb/tb_mem_wb_sender.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_sender.sv
// mem_wb_sender: MEM stage; buffers the data-SRAM load response, extends load data, hands off to WB.
// Optional MEM_FWD_EN drives the forwarding/stall bundle to ID; otherwise it is tied to 0.
module mem_wb_sender #(
  parameter int BUS_E2M = 74,
  parameter int BUS_M2W = 70
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exe_to_mem_valid,
  input  logic [BUS_E2M-1:0] exe_to_mem_bus,
  output logic               mem_allowin,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata,
  input  logic               wb_allowin,
  output logic               mem_to_wb_valid,
  output logic [BUS_M2W-1:0] mem_to_wb_bus,
  output logic [38:0]        mem_fwd_zip
);
  typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;
  state_t state, state_nx;
  logic mem_valid, mem_ready_go, accept, load_in, ok, buf_valid;
  logic [BUS_E2M-1:0] payload;
  logic [31:0] buf_rdata, raw, alu_result, pc, rf_wdata, extracted;
  logic [15:0] half_sel;
  logic [7:0] byte_sel;
  logic [4:0] rf_waddr;
  logic [2:0] ld_type;
  logic res_from_mem, rf_we;
  assign {res_from_mem, ld_type, rf_we, rf_waddr, alu_result, pc} = payload;
  // data_ok only counts while a load is actually outstanding
  assign ok           = data_sram_data_ok & (state == WAIT);
  assign buf_valid    = state == HELD;
  assign mem_ready_go = ~res_from_mem | ok | buf_valid;
  assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go;
  assign accept  = exe_to_mem_valid & mem_allowin;
  assign load_in = accept & exe_to_mem_bus[BUS_E2M-1];
  always_comb begin
    state_nx = IDLE;
    if (load_in) state_nx = WAIT;
    else if (state == WAIT) state_nx = ok ? (wb_allowin ? IDLE : HELD) : WAIT;
    else if (state == HELD) state_nx = wb_allowin ? IDLE : HELD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (mem_allowin) mem_valid <= exe_to_mem_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) payload <= exe_to_mem_bus;
    if (ok && !wb_allowin) buf_rdata <= data_sram_rdata;
  end
  assign raw      = buf_valid ? buf_rdata : data_sram_rdata;
  assign byte_sel = raw[{alu_result[1:0], 3'b000} +: 8];
  assign half_sel = alu_result[1] ? raw[31:16] : raw[15:0];
  assign extracted = ld_type == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
                     ld_type == 3'b100 ? {24'b0, byte_sel} :
                     ld_type == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
                     ld_type == 3'b101 ? {16'b0, half_sel} :
                     ld_type == 3'b010 ? raw : 32'b0;
  assign rf_wdata      = res_from_mem ? extracted : alu_result;
  assign mem_to_wb_bus = {rf_we, rf_waddr, rf_wdata, pc};
`ifdef MEM_FWD_EN
  assign mem_fwd_zip = {mem_valid & rf_we & (rf_waddr != 5'd0),
                        mem_valid & res_from_mem & ~mem_ready_go, rf_waddr, rf_wdata};
`else
  assign mem_fwd_zip = 39'b0;
`endif
endmodule

// File: tb/tb_mem_wb_sender.sv
// tb_mem_wb_sender: directed self-checking bench for mem_wb_sender.
module tb_mem_wb_sender;
  logic clk = 0, reset = 1, exe_to_mem_valid = 0, data_sram_data_ok = 0, wb_allowin = 1;
  logic [73:0] exe_to_mem_bus = '0;
  logic [31:0] data_sram_rdata = '0;
  logic mem_allowin, mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [38:0] mem_fwd_zip;
  int checks = 0, errors = 0;

  mem_wb_sender dut (.clk(clk), .reset(reset), .exe_to_mem_valid(exe_to_mem_valid),
    .exe_to_mem_bus(exe_to_mem_bus), .mem_allowin(mem_allowin),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid),
    .mem_to_wb_bus(mem_to_wb_bus), .mem_fwd_zip(mem_fwd_zip));

  always #5 clk = ~clk;

  function automatic logic [73:0] mk(input logic res, input logic [2:0] ld, input logic we,
                                     input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] pc);
    return {res, ld, we, wa, alu, pc};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; step(); step();
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", mem_to_wb_valid); end
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin: got %b exp 1", mem_allowin); end
    checks++; if (mem_fwd_zip !== 39'b0) begin errors++; $display("FAIL rst_zip: got %h exp 0", mem_fwd_zip); end
    step(); reset = 0;
  endtask

  task automatic test_nonload();
    exe_to_mem_valid = 1; wb_allowin = 1;
    exe_to_mem_bus = mk(0, 3'b000, 1, 5'd5, 32'h1234_5678, 32'h1C00_0000);
    step(); exe_to_mem_valid = 0;
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL nl_valid: got %b exp 1", mem_to_wb_valid); end
    checks++; if (mem_to_wb_bus !== {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000}) begin errors++; $display("FAIL nl_bus: got %h exp %h", mem_to_wb_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000}); end
    step();
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL nl_drain: got %b exp 0", mem_to_wb_valid); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  lt[7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b000};
    logic [1:0]  ad[7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [31:0] rd[7] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h1234_F00D,
                           32'hCAFE_BABE, 32'hCAFE_BABE, 32'h0000_7F00};
    logic [31:0] ex[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_F00D,
                           32'hCAFE_BABE, 32'h0000_0000, 32'h0000_007F};
    for (int i = 0; i < 7; i++) begin
      exe_to_mem_valid = 1; wb_allowin = 1;
      exe_to_mem_bus = mk(1, lt[i], 1, 5'd3, 32'h1000_0000 | {30'b0, ad[i]}, 32'h1C00_0010);
      step(); exe_to_mem_valid = 0; data_sram_data_ok = 1; data_sram_rdata = rd[i];
      @(negedge clk);
      checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL ld%0d_valid: got %b exp 1", i, mem_to_wb_valid); end
      checks++; if (mem_to_wb_bus !== {1'b1, 5'd3, ex[i], 32'h1C00_0010}) begin errors++; $display("FAIL ld%0d_bus: got %h exp %h", i, mem_to_wb_bus, {1'b1, 5'd3, ex[i], 32'h1C00_0010}); end
      step(); data_sram_data_ok = 0;
    end
  endtask

  task automatic test_late_load();
    exe_to_mem_valid = 1; wb_allowin = 1;
    exe_to_mem_bus = mk(1, 3'b010, 1, 5'd9, 32'h1000_0004, 32'h1C00_0020);
    step(); exe_to_mem_valid = 0; data_sram_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mem_allowin !== 1'b0) begin errors++; $display("FAIL late%0d_allowin: got %b exp 0", i, mem_allowin); end
      checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL late%0d_valid: got %b exp 0", i, mem_to_wb_valid); end
`ifdef MEM_FWD_EN
      checks++; if (mem_fwd_zip[38:37] !== 2'b11) begin errors++; $display("FAIL late%0d_pending: got %b exp 11", i, mem_fwd_zip[38:37]); end
`else
      checks++; if (mem_fwd_zip !== 39'b0) begin errors++; $display("FAIL late%0d_zip: got %h exp 0", i, mem_fwd_zip); end
`endif
      step();
    end
    data_sram_data_ok = 1; data_sram_rdata = 32'h1122_3344;
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL late_valid: got %b exp 1", mem_to_wb_valid); end
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL late_allowin: got %b exp 1", mem_allowin); end
    checks++; if (mem_to_wb_bus[63:32] !== 32'h1122_3344) begin errors++; $display("FAIL late_wdata: got %h exp 11223344", mem_to_wb_bus[63:32]); end
    step(); data_sram_data_ok = 0;
  endtask

  task automatic test_held();
    exe_to_mem_valid = 1; wb_allowin = 1;
    exe_to_mem_bus = mk(1, 3'b010, 1, 5'd4, 32'h1000_0008, 32'h1C00_0030);
    step(); exe_to_mem_valid = 0; wb_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL held_valid0: got %b exp 1", mem_to_wb_valid); end
    checks++; if (mem_allowin !== 1'b0) begin errors++; $display("FAIL held_allowin0: got %b exp 0", mem_allowin); end
    step(); data_sram_data_ok = 0; data_sram_rdata = 32'h0BAD_F00D;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL held_valid%0d: got %b exp 1", i, mem_to_wb_valid); end
      checks++; if (mem_to_wb_bus !== {1'b1, 5'd4, 32'hDEAD_BEEF, 32'h1C00_0030}) begin errors++; $display("FAIL held_bus%0d: got %h exp %h", i, mem_to_wb_bus, {1'b1, 5'd4, 32'hDEAD_BEEF, 32'h1C00_0030}); end
      if (i == 1) step();
    end
    wb_allowin = 1; #1;
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL held_release: got %b exp 1", mem_allowin); end
    step(); data_sram_data_ok = 1; data_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL held_stray_valid: got %b exp 0", mem_to_wb_valid); end
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL held_stray_allowin: got %b exp 1", mem_allowin); end
    step(); data_sram_data_ok = 0;
  endtask

  task automatic test_reset_mid_load();
    exe_to_mem_valid = 1; wb_allowin = 1;
    exe_to_mem_bus = mk(1, 3'b010, 1, 5'd6, 32'h1000_000C, 32'h1C00_0040);
    step(); exe_to_mem_valid = 0; reset = 1;
    step(); reset = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h7777_7777;
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b exp 0", mem_to_wb_valid); end
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL rmid_allowin: got %b exp 1", mem_allowin); end
    step(); data_sram_data_ok = 0;
    exe_to_mem_valid = 1;
    step(); exe_to_mem_valid = 0;
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_wait: got %b exp 0", mem_to_wb_valid); end
    step(); data_sram_data_ok = 1; data_sram_rdata = 32'h600D_F00D;
    @(negedge clk);
    checks++; if (mem_to_wb_bus[63:32] !== 32'h600D_F00D || mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL rmid_done: got %b/%h exp 1/600df00d", mem_to_wb_valid, mem_to_wb_bus[63:32]); end
    step(); data_sram_data_ok = 0;
  endtask

  task automatic test_back_to_back();
    exe_to_mem_valid = 1; wb_allowin = 1;
    exe_to_mem_bus = mk(1, 3'b010, 1, 5'd1, 32'h1000_0000, 32'h1C00_0050);
    step();
    exe_to_mem_bus = mk(1, 3'b100, 1, 5'd2, 32'h1000_0001, 32'h1C00_0054);
    data_sram_data_ok = 1; data_sram_rdata = 32'hAAAA_BBBB;
    @(negedge clk);
    checks++; if (mem_to_wb_bus[63:32] !== 32'hAAAA_BBBB || mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b/%h exp 1/aaaabbbb", mem_to_wb_valid, mem_to_wb_bus[63:32]); end
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin: got %b exp 1", mem_allowin); end
    step(); exe_to_mem_valid = 0; data_sram_data_ok = 0; data_sram_rdata = 32'h0000_CC00;
    @(negedge clk);
    checks++; if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %b%b exp 00", mem_to_wb_valid, mem_allowin); end
    step(); data_sram_data_ok = 1;
    @(negedge clk);
    checks++; if (mem_to_wb_bus !== {1'b1, 5'd2, 32'h0000_00CC, 32'h1C00_0054} || mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b/%h exp 1/%h", mem_to_wb_valid, mem_to_wb_bus, {1'b1, 5'd2, 32'h0000_00CC, 32'h1C00_0054}); end
    step(); data_sram_data_ok = 0;
  endtask

  task automatic test_fwd();
    exe_to_mem_valid = 1; wb_allowin = 0;
    exe_to_mem_bus = mk(0, 3'b000, 1, 5'd7, 32'hABCD_0123, 32'h1C00_0060);
    step(); exe_to_mem_valid = 0;
    @(negedge clk);
`ifdef MEM_FWD_EN
    checks++; if (mem_fwd_zip !== {1'b1, 1'b0, 5'd7, 32'hABCD_0123}) begin errors++; $display("FAIL fwd_zip: got %h exp %h", mem_fwd_zip, {1'b1, 1'b0, 5'd7, 32'hABCD_0123}); end
`else
    checks++; if (mem_fwd_zip !== 39'b0) begin errors++; $display("FAIL fwd_zip: got %h exp 0", mem_fwd_zip); end
`endif
    checks++; if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %b%b exp 10", mem_to_wb_valid, mem_allowin); end
    wb_allowin = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_load_ext();
    test_late_load();
    test_held();
    test_reset_mid_load();
    test_back_to_back();
    test_fwd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
